fetch_stage: RTL and testbench

- Instruction-fetch stage directly upstream of the decode stage.
- Holds the fetch PC and issues read requests to instruction memory with a request/response handshake.
- Buffers returned instructions in a small FIFO and presents {pc, instruction, valid} to decode, with backpressure from decode.
- On a redirect (mispredicted control flow resolved downstream), flushes the FIFO, squashes any in-flight fetch, and restarts at the new PC.

---
 rtl/fetch_if.sv | 28 ++
 rtl/fetch_stage.sv | 134 +++++++++++++
 tb/tb_fetch_stage.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, redirect input
// and the {pc, instr, pred} output toward decode.
interface fetch_if;
  // Handshakes: imem_read/imem_address are held steady until the cycle imem_resp
  // is high, which completes the single outstanding read. Toward decode, an entry
  // moves when out_valid && id_ready on a rising clock edge, unless redirect is high.
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_read;
  logic [31:0] imem_address;
  logic        imem_resp;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_pred_taken;
  logic        id_ready;

  modport master (
    input  redirect, redirect_pc, imem_resp, imem_rdata, id_ready,
    output imem_read, imem_address, out_valid, out_pc, out_instr, out_pred_taken
  );

  modport slave (
    output redirect, redirect_pc, imem_resp, imem_rdata, id_ready,
    input  imem_read, imem_address, out_valid, out_pc, out_instr, out_pred_taken
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: one outstanding imem read, small FIFO toward decode,
// redirect flush/squash. Optional jal prediction under FETCH_JAL_PREDICT_EN.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0060,
  parameter int          DEPTH    = 2
) (
  input  logic    clk,
  input  logic    rst,
  fetch_if.master bus
);
  localparam int            AW      = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [31:0]   pc_q, pc_d;
  logic [31:0]   addr_q, addr_d;
  logic          req_q, req_d;
  logic          drop_q, drop_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [31:0]   fifo_pc_q    [DEPTH];
  logic [31:0]   fifo_pc_d    [DEPTH];
  logic [31:0]   fifo_instr_q [DEPTH];
  logic [31:0]   fifo_instr_d [DEPTH];
  logic          fifo_pred_q  [DEPTH];
  logic          fifo_pred_d  [DEPTH];

  logic        resp_fire, push, pop, pred;
  logic [31:0] next_pc;

`ifdef FETCH_JAL_PREDICT_EN
  logic        is_jal;
  logic [31:0] j_imm;

  always_comb begin
    is_jal  = (bus.imem_rdata[6:0] == 7'b1101111);
    j_imm   = {{11{bus.imem_rdata[31]}}, bus.imem_rdata[31], bus.imem_rdata[19:12],
               bus.imem_rdata[20], bus.imem_rdata[30:21], 1'b0};
    pred    = is_jal;
    next_pc = is_jal ? (addr_q + j_imm) : (pc_q + 32'd4);
  end
`else
  always_comb begin
    pred    = 1'b0;
    next_pc = pc_q + 32'd4;
  end
`endif

  always_comb begin
    resp_fire    = bus.imem_resp && req_q;
    push         = resp_fire && !drop_q && !bus.redirect;
    pop          = (count_q != '0) && bus.id_ready && !bus.redirect;

    pc_d         = pc_q;
    addr_d       = addr_q;
    req_d        = 1'b0;
    drop_d       = drop_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    fifo_pc_d    = fifo_pc_q;
    fifo_instr_d = fifo_instr_q;
    fifo_pred_d  = fifo_pred_q;

    if (bus.redirect) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      pc_d     = bus.redirect_pc & 32'hFFFF_FFFC;
    end else begin
      if (push) begin
        fifo_pc_d[wr_ptr_q]    = addr_q;
        fifo_instr_d[wr_ptr_q] = bus.imem_rdata;
        fifo_pred_d[wr_ptr_q]  = pred;
        wr_ptr_d               = wr_ptr_q + PTR_ONE;
        pc_d                   = next_pc;
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end

    // A completing response always consumes the pending squash, even when a
    // fresh redirect lands in the same cycle: that response is the squashed one.
    if (resp_fire)                  drop_d = 1'b0;
    else if (bus.redirect && req_q) drop_d = 1'b1;

    // count_d already includes this cycle's push, so an issued read always has a slot.
    if (req_q && !bus.imem_resp) begin
      req_d = 1'b1;
    end else if (!bus.redirect && (count_d < CNT_MAX)) begin
      req_d  = 1'b1;
      addr_d = pc_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q         <= RESET_PC;
      addr_q       <= '0;
      req_q        <= 1'b0;
      drop_q       <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      fifo_pc_q    <= '{default: '0};
      fifo_instr_q <= '{default: '0};
      fifo_pred_q  <= '{default: 1'b0};
    end else begin
      pc_q         <= pc_d;
      addr_q       <= addr_d;
      req_q        <= req_d;
      drop_q       <= drop_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      fifo_pc_q    <= fifo_pc_d;
      fifo_instr_q <= fifo_instr_d;
      fifo_pred_q  <= fifo_pred_d;
    end
  end

  assign bus.imem_read      = req_q;
  assign bus.imem_address   = addr_q;
  assign bus.out_valid      = (count_q != '0);
  assign bus.out_pc         = bus.out_valid ? fifo_pc_q[rd_ptr_q]    : 32'd0;
  assign bus.out_instr      = bus.out_valid ? fifo_instr_q[rd_ptr_q] : 32'd0;
  assign bus.out_pred_taken = bus.out_valid ? fifo_pred_q[rd_ptr_q]  : 1'b0;
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: latency-programmable memory model, accepted
// request/output logs compared against hand-computed expected queues.
module tb_fetch_stage;
  logic clk;
  logic rst;
  fetch_if bus();

  fetch_stage #(.RESET_PC(32'h0000_0060), .DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

`ifdef FETCH_JAL_PREDICT_EN
  localparam logic [31:0] EXP_JAL_NEXT = 32'h0000_0070;
  localparam logic        EXP_JAL_PRED = 1'b1;
`else
  localparam logic [31:0] EXP_JAL_NEXT = 32'h0000_0064;
  localparam logic        EXP_JAL_PRED = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  int   mem_lat  = 1;
  int   age      = 0;
  bit   stray    = 1'b0;
  bit   jal_mode = 1'b0;

  logic [31:0] req_log[$];
  logic [31:0] pc_log[$];
  logic [31:0] instr_log[$];
  logic        pred_log[$];
  logic [31:0] exp_q[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (jal_mode && a == 32'h0000_0060) ? 32'h0100_006F : a;
  endfunction

  // Memory model: answers mem_lat cycles after a read is first seen.
  always @(negedge clk) begin
    if (bus.imem_resp) begin
      bus.imem_resp = 1'b0;
      age = 0;
    end
    if (stray) begin
      bus.imem_resp  = 1'b1;
      bus.imem_rdata = 32'hBAD0_0BAD;
    end else if (bus.imem_read) begin
      if (age == mem_lat) begin
        bus.imem_resp  = 1'b1;
        bus.imem_rdata = mem_word(bus.imem_address);
      end else begin
        age++;
      end
    end else begin
      age = 0;
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic score_reqs(input string tag);
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("%s_req%0d", tag, i),
            (i < req_log.size()) ? req_log[i] : 32'hxxxx_xxxx, exp_q[i]);
    exp_q.delete();
  endtask

  task automatic score_pops(input string tag);
    for (int i = 0; i < exp_q.size(); i++) begin
      check($sformatf("%s_pc%0d", tag, i),
            (i < pc_log.size()) ? pc_log[i] : 32'hxxxx_xxxx, exp_q[i]);
      check($sformatf("%s_instr%0d", tag, i),
            (i < instr_log.size()) ? instr_log[i] : 32'hxxxx_xxxx, exp_q[i]);
    end
    exp_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  // Logs what the upcoming edge will accept, then moves to just after the next negedge.
  task automatic cyc();
    if (rst) begin
      if (bus.imem_read && bus.imem_resp) req_log.push_back(bus.imem_address);
      if (bus.out_valid && bus.id_ready && !bus.redirect) begin
        pc_log.push_back(bus.out_pc);
        instr_log.push_back(bus.out_instr);
        pred_log.push_back(bus.out_pred_taken);
      end
    end
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = '0;
    #1;
    check("rst_read",  bus.imem_read,      0);
    check("rst_valid", bus.out_valid,      0);
    check("rst_pc",    bus.out_pc,         0);
    check("rst_instr", bus.out_instr,      0);
    check("rst_pred",  bus.out_pred_taken, 0);
    cyc();
    cyc();
    req_log.delete();
    pc_log.delete();
    instr_log.delete();
    pred_log.delete();
    stray = 1'b0;
    rst = 1'b1;
  endtask

  task automatic run_until_pops(input int n, input string tag);
    for (int i = 0; i < 200 && pc_log.size() < n; i++) cyc();
    check({tag, "_pop_budget"}, pc_log.size() >= n, 1);
  endtask

  task automatic wait_req(input logic [31:0] a);
    for (int i = 0; i < 100; i++) begin
      if (bus.imem_read && bus.imem_address == a) break;
      cyc();
    end
    check("wait_req", bus.imem_read && bus.imem_address == a, 1);
  endtask

  task automatic wait_resp(input logic [31:0] a);
    for (int i = 0; i < 100; i++) begin
      if (bus.imem_resp && bus.imem_address == a) break;
      cyc();
    end
    check("wait_resp", bus.imem_resp && bus.imem_address == a, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = '0;
    bus.imem_resp = 1'b0;
    bus.imem_rdata = '0;
    bus.id_ready = 1'b1;

    // Streaming, with a stray response at reset release that must be ignored.
    stray = 1'b1;
    mem_lat = 1;
    do_reset();
    cyc();
    check("a_read",  bus.imem_read,    1);
    check("a_addr",  bus.imem_address, 32'h60);
    check("a_empty", bus.out_valid,    0);
    cyc();
    cyc();
    check("a_valid", bus.out_valid, 1);
    check("a_pc",    bus.out_pc,    32'h60);
    check("a_instr", bus.out_instr, 32'h60);
    run_until_pops(3, "a");
    exp_q = '{32'h60, 32'h64, 32'h68};
    score_reqs("a");
    exp_q = '{32'h60, 32'h64, 32'h68};
    score_pops("a");

    // Backpressure: FIFO fills, fetch stalls, then drains.
    bus.id_ready = 1'b0;
    do_reset();
    repeat (5) cyc();
    check("b_stall_read", bus.imem_read, 0);
    check("b_full_valid", bus.out_valid, 1);
    check("b_head_pc",    bus.out_pc,    32'h60);
    repeat (3) cyc();
    check("b_still_read", bus.imem_read, 0);
    check("b_still_pc",   bus.out_pc,    32'h60);
    bus.id_ready = 1'b1;
    cyc();
    check("b_resume_read", bus.imem_read,    1);
    check("b_resume_addr", bus.imem_address, 32'h68);
    check("b_second_pc",   bus.out_pc,       32'h64);
    run_until_pops(3, "b");
    exp_q = '{32'h60, 32'h64, 32'h68};
    score_reqs("b");
    exp_q = '{32'h60, 32'h64, 32'h68};
    score_pops("b");

    // Redirect while 0x68 is outstanding with a 3-cycle memory.
    mem_lat = 3;
    do_reset();
    wait_req(32'h68);
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h200;
    cyc();
    bus.redirect = 1'b0;
    check("c_hold_read", bus.imem_read,    1);
    check("c_hold_addr", bus.imem_address, 32'h68);
    check("c_flushed",   bus.out_valid,    0);
    run_until_pops(2, "c");
    exp_q = '{32'h60, 32'h64, 32'h68, 32'h200};
    score_reqs("c");
    exp_q = '{32'h60, 32'h200};
    score_pops("c");

    // Two back-to-back redirects while the squashed read is still pending.
    do_reset();
    wait_req(32'h68);
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h200;
    cyc();
    bus.redirect_pc = 32'h300;
    cyc();
    bus.redirect = 1'b0;
    check("e_hold_addr", bus.imem_address, 32'h68);
    run_until_pops(2, "e");
    exp_q = '{32'h60, 32'h64, 32'h68, 32'h300};
    score_reqs("e");
    exp_q = '{32'h60, 32'h300};
    score_pops("e");

    // Redirect coinciding with the 0x64 response; unaligned target.
    mem_lat = 1;
    do_reset();
    wait_resp(32'h64);
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h203;
    cyc();
    bus.redirect = 1'b0;
    check("d_no_read", bus.imem_read, 0);
    check("d_flushed", bus.out_valid, 0);
    cyc();
    check("d_read", bus.imem_read,    1);
    check("d_addr", bus.imem_address, 32'h200);
    run_until_pops(3, "d");
    exp_q = '{32'h60, 32'h64, 32'h200, 32'h204};
    score_reqs("d");
    exp_q = '{32'h60, 32'h200, 32'h204};
    score_pops("d");

    // PC wrap at the top of the address space.
    do_reset();
    wait_req(32'h60);
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFFC;
    cyc();
    bus.redirect = 1'b0;
    run_until_pops(2, "g");
    exp_q = '{32'h60, 32'hFFFF_FFFC, 32'h0};
    score_reqs("g");
    exp_q = '{32'hFFFF_FFFC, 32'h0};
    score_pops("g");

    // jal at 0x60: predicted target when the feature is built in.
    jal_mode = 1'b1;
    do_reset();
    run_until_pops(2, "f");
    check("f_instr0", instr_log[0], 32'h0100_006F);
    check("f_pred0",  pred_log[0],  EXP_JAL_PRED);
    check("f_req1",   req_log[1],   EXP_JAL_NEXT);
    check("f_pc1",    pc_log[1],    EXP_JAL_NEXT);
    check("f_pred1",  pred_log[1],  0);
    jal_mode = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1);
  end
endmodule
